// File: rtl/rx_txn_controller.sv
// Read-transaction controller for an IN/DATA0 exchange: it issues the IN token, waits for data,
// and answers with ACK or NAK. Failed attempts are retried until MAX_TRIES is reached.
module rx_txn_controller #(
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic        tok_done,
  input  logic        hs_done,
  input  logic        havepkt,
  input  logic        error,
  input  logic        haveack,
  input  logic        havenak,
  input  logic [63:0] dec_data,
  output logic        send_in,
  output logic        send_ack,
  output logic        send_nak,
  output logic [63:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEND_TOK  = 4'd1,
    WAIT_TOK  = 4'd2,
    WAIT_DATA = 4'd3,
    SEND_ACK  = 4'd4,
    WAIT_ACK  = 4'd5,
    SEND_NAK  = 4'd6,
    WAIT_NAK  = 4'd7,
    FINISH    = 4'd8,
    ABORT     = 4'd9
  } state_t;

  localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);
  localparam logic [9:0] TMO_LAST_C  = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  try_q, try_d, try_inc_s;
  logic [9:0]  tmo_q, tmo_d;
  logic [63:0] data_q, data_d;
  logic        send_in_q, send_ack_q, send_nak_q, busy_q, done_q, fail_q;

  assign try_inc_s = try_q + 4'd1;

  // Next-state, retry bookkeeping and payload capture.
  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND_TOK;
          try_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_TOK: state_d = WAIT_TOK;
      WAIT_TOK: begin
        if (tok_done) begin
          state_d = WAIT_DATA;
          tmo_d   = 10'd0;
        end else begin
          state_d = WAIT_TOK;
        end
      end
      WAIT_DATA: begin
        // A corrupted packet outranks a good one in the same cycle.
        if (error) begin
          try_d   = try_inc_s;
          state_d = SEND_NAK;
        end else if (havepkt) begin
          data_d  = dec_data;
          state_d = SEND_ACK;
        end else if (havenak || haveack || (tmo_q == TMO_LAST_C)) begin
          try_d   = try_inc_s;
          state_d = (try_inc_s == MAX_TRIES_C) ? ABORT : SEND_TOK;
        end else begin
          tmo_d   = tmo_q + 10'd1;
        end
      end
      SEND_ACK: state_d = WAIT_ACK;
      SEND_NAK: state_d = WAIT_NAK;
      WAIT_ACK: begin
        if (hs_done) begin
          state_d = FINISH;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_NAK: begin
        if (hs_done) begin
          state_d = (try_q == MAX_TRIES_C) ? ABORT : SEND_TOK;
        end else begin
          state_d = WAIT_NAK;
        end
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, payload and outputs; outputs are decoded from the next state so they
  // line up with the state they describe while still coming straight from flops.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      try_q      <= 4'd0;
      tmo_q      <= 10'd0;
      data_q     <= 64'd0;
      send_in_q  <= 1'b0;
      send_ack_q <= 1'b0;
      send_nak_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      try_q      <= try_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      send_in_q  <= (state_d == SEND_TOK);
      send_ack_q <= (state_d == SEND_ACK);
      send_nak_q <= (state_d == SEND_NAK);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FINISH);
      fail_q     <= (state_d == ABORT);
    end
  end

  assign send_in  = send_in_q;
  assign send_ack = send_ack_q;
  assign send_nak = send_nak_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_rx_txn_controller.sv
// Directed bench for rx_txn_controller with default TIMEOUT=200 and MAX_TRIES=8.
module tb_rx_txn_controller;

  logic        clk = 1'b0;
  logic        rst_L, start, tok_done, hs_done, havepkt, error, haveack, havenak;
  logic [63:0] dec_data;
  logic        send_in, send_ack, send_nak, busy, done, fail;
  logic [63:0] data_out;

  int checks = 0;
  int errors = 0;
  int n_in = 0, n_ack = 0, n_nak = 0, n_done = 0, n_fail = 0, n_both = 0;
  int b_in, b_ack, b_nak, b_done, b_fail;
  int wait_n;

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2 = 64'h0F0F_1234_5678_9ABC;
  localparam logic [63:0] DB = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [63:0] D3 = 64'hCAFE_F00D_0000_0001;
  localparam logic [63:0] D4 = 64'h5555_AAAA_5555_AAAA;

  rx_txn_controller dut (
    .clk(clk), .rst_L(rst_L), .start(start), .tok_done(tok_done), .hs_done(hs_done),
    .havepkt(havepkt), .error(error), .haveack(haveack), .havenak(havenak),
    .dec_data(dec_data), .send_in(send_in), .send_ack(send_ack), .send_nak(send_nak),
    .data_out(data_out), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_in)     n_in   <= n_in + 1;
    if (send_ack)    n_ack  <= n_ack + 1;
    if (send_nak)    n_nak  <= n_nak + 1;
    if (done)        n_done <= n_done + 1;
    if (fail)        n_fail <= n_fail + 1;
    if (done && fail) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_in = n_in; b_ack = n_ack; b_nak = n_nak; b_done = n_done; b_fail = n_fail;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic do_tok();
    tok_done = 1'b1; tick(); tok_done = 1'b0;
  endtask
  task automatic do_hs();
    hs_done = 1'b1; tick(); hs_done = 1'b0;
  endtask
  task automatic do_pkt(input logic [63:0] d);
    havepkt = 1'b1; dec_data = d; tick(); havepkt = 1'b0; dec_data = 64'd0;
  endtask
  task automatic do_err();
    error = 1'b1; tick(); error = 1'b0;
  endtask

  initial begin
    rst_L = 1'b0; start = 1'b0; tok_done = 1'b0; hs_done = 1'b0;
    havepkt = 1'b0; error = 1'b0; haveack = 1'b0; havenak = 1'b0; dec_data = 64'd0;
    repeat (2) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_outs", {59'd0, send_in, send_ack, send_nak, done, fail}, 64'd0);
    rst_L = 1'b1;

    // Single clean transaction; start accepted on the first edge after reset release.
    snap();
    do_start();
    chk("t1_send_in_lat", {63'd0, send_in}, 64'd1);
    tick();
    do_tok();
    do_pkt(D1);
    chk("t1_send_ack_lat", {63'd0, send_ack}, 64'd1);
    tick();
    do_hs();
    chk("t1_done_lat", {63'd0, done}, 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy_after", {63'd0, busy}, 64'd0);
    chk("t1_start_in_finish_dropped", {63'd0, send_in}, 64'd0);
    chk("t1_data", data_out, D1);
    chk("t1_counts", {32'(n_in - b_in), 32'(n_ack - b_ack)}, {32'd1, 32'd1});
    // Stray pulses while idle change nothing.
    havepkt = 1'b1; dec_data = D4; hs_done = 1'b1; tok_done = 1'b1; tick();
    havepkt = 1'b0; dec_data = 64'd0; hs_done = 1'b0; tok_done = 1'b0; tick();
    chk("idle_stray_busy", {63'd0, busy}, 64'd0);
    chk("idle_stray_data", data_out, D1);

    // Error on attempt 1, good packet on attempt 2.
    snap();
    do_start(); tick(); do_tok();
    do_err();
    chk("t2_send_nak", {63'd0, send_nak}, 64'd1);
    tick();
    do_hs();
    chk("t2_retry_send_in", {63'd0, send_in}, 64'd1);
    tick(); do_tok();
    do_pkt(D2); tick(); do_hs();
    chk("t2_done", {63'd0, done}, 64'd1);
    tick();
    chk("t2_counts", {16'(n_in - b_in), 16'(n_nak - b_nak), 16'(n_ack - b_ack), 16'(n_done - b_done)},
        {16'd2, 16'd1, 16'd1, 16'd1});
    chk("t2_no_fail", 64'(n_fail - b_fail), 64'd0);
    chk("t2_data", data_out, D2);

    // Error on every attempt exhausts MAX_TRIES.
    snap();
    do_start();
    for (int i = 0; i < 8; i++) begin
      tick(); do_tok(); do_err(); tick(); do_hs();
    end
    chk("t3_fail_pulse", {62'd0, fail, done}, 64'd2);
    tick();
    chk("t3_counts", {16'(n_in - b_in), 16'(n_nak - b_nak), 16'(n_done - b_done), 16'(n_fail - b_fail)},
        {16'd8, 16'd8, 16'd0, 16'd1});
    chk("t3_data", data_out, D2);
    chk("t3_idle", {63'd0, busy}, 64'd0);

    // Timeout reissues the token; then error+havepkt, device NAK, and finally a good packet.
    snap();
    do_start(); tick(); do_tok();
    wait_n = 0;
    while (!send_in && wait_n < 400) begin
      tick(); wait_n++;
    end
    chk("t4_timeout_cycles", 64'(wait_n + 1), 64'd201);
    chk("t4_no_nak", 64'(n_nak - b_nak), 64'd0);
    tick(); do_tok();
    error = 1'b1; havepkt = 1'b1; dec_data = DB; tick();
    error = 1'b0; havepkt = 1'b0; dec_data = 64'd0;
    chk("t4_err_beats_pkt", {62'd0, send_nak, send_ack}, 64'd2);
    chk("t4_data_kept", data_out, D2);
    tick(); do_hs();
    tick(); do_tok();
    havenak = 1'b1; tick(); havenak = 1'b0;
    chk("t4_devnak_retry", {62'd0, send_in, send_nak}, 64'd2);
    tick(); do_tok();
    do_pkt(D3); tick(); do_hs(); tick();
    chk("t4_data_final", data_out, D3);
    chk("t4_counts", {16'(n_in - b_in), 16'(n_nak - b_nak), 16'(n_ack - b_ack), 16'(n_done - b_done)},
        {16'd4, 16'd1, 16'd1, 16'd1});

    // Start while busy is dropped; reset in WAIT_ACK discards the transaction.
    snap();
    do_start(); tick();
    do_start();
    do_tok();
    chk("t5_no_extra_send_in", 64'(n_in - b_in), 64'd1);
    do_pkt(D4); tick();
    chk("t5_data_captured", data_out, D4);
    rst_L = 1'b0; #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_data", data_out, 64'd0);
    hs_done = 1'b1; tick(); hs_done = 1'b0; tick();
    chk("t5_no_done", 64'(n_done - b_done), 64'd0);
    chk("t5_no_fail", 64'(n_fail - b_fail), 64'd0);
    rst_L = 1'b1;
    do_start();
    chk("t5_start_after_rst", {63'd0, send_in}, 64'd1);
    tick();
    chk("never_done_and_fail", 64'(n_both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
